// File: rtl/miss_arbiter.sv
// Shares the single-ported main memory between I-cache line fills, D-cache line fills
// and D-cache write-through stores, and steers returned fill words to the owning cache.
//
// state | meaning
// IDLE  | arbitrate the held request levels every cycle
// IFILL | issue and collect the WORDS reads of an I-cache line
// DFILL | issue and collect the WORDS reads of a D-cache line
// WRITE | single-cycle write-through store
module miss_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_miss,
  input  logic [15:0] ic_miss_addr,
  input  logic        dc_miss,
  input  logic [15:0] dc_miss_addr,
  input  logic        dc_wr_req,
  input  logic [15:0] dc_wr_addr,
  input  logic [15:0] dc_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic [15:0] fill_addr,
  output logic [15:0] fill_data,
  output logic        ic_fill_we,
  output logic        dc_fill_we,
  output logic        ic_fill_done,
  output logic        dc_fill_done,
  output logic        wr_ack,
  output logic        busy
);

  if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_words
    $error("miss_arbiter: WORDS must be a power of 2 and at least 2");
  end
  if (MEM_LAT < 1) begin : g_bad_lat
    $error("miss_arbiter: MEM_LAT must be at least 1");
  end

  localparam int               CNT_W     = $clog2(WORDS) + 1;
  localparam logic [15:0]      LINE_MASK = ~16'(2 * WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_WORDS = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORDS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IFILL = 2'd1;
  localparam logic [1:0] DFILL = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       grant_state;
  logic [15:0]      line_base;
  logic [15:0]      grant_addr;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic             last_data;
  logic             in_fill;
  logic             issuing;
  logic             returning;
  logic             last_return;

  function automatic logic [15:0] word_addr(input logic [15:0] base,
                                            input logic [CNT_W-1:0] idx);
    return base + 16'({idx, 1'b0});
  endfunction

  // Data side normally wins, but an I miss goes first once the data side has had its turn.
  always_comb begin
    grant_state = IDLE;
    if (ic_miss && last_data)
      grant_state = IFILL;
    else if (dc_miss)
      grant_state = DFILL;
    else if (dc_wr_req)
      grant_state = WRITE;
    else if (ic_miss)
      grant_state = IFILL;
  end

  assign grant_addr  = (grant_state == DFILL) ? dc_miss_addr : ic_miss_addr;
  assign in_fill     = (state == IFILL) || (state == DFILL);
  assign issuing     = in_fill && (issue_cnt < CNT_WORDS);
  assign returning   = in_fill && mem_data_valid;
  assign last_return = returning && (recv_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      line_base <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      last_data <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_state != IDLE) begin
            state     <= grant_state;
            line_base <= grant_addr & LINE_MASK;
            issue_cnt <= '0;
            recv_cnt  <= '0;
          end
        end
        IFILL, DFILL: begin
          if (issuing)
            issue_cnt <= issue_cnt + 1'b1;
          if (returning)
            recv_cnt <= recv_cnt + 1'b1;
          if (last_return) begin
            state     <= IDLE;
            last_data <= (state == DFILL);
          end
        end
        default: begin
          state     <= IDLE;
          last_data <= 1'b1;
        end
      endcase
    end
  end

  // Address/data outputs are held at zero whenever their strobe is low.
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_addr    = '0;
    fill_data    = '0;
    ic_fill_we   = 1'b0;
    dc_fill_we   = 1'b0;
    ic_fill_done = 1'b0;
    dc_fill_done = 1'b0;
    wr_ack       = 1'b0;
    busy         = (state != IDLE);
    if (issuing) begin
      mem_en   = 1'b1;
      mem_addr = word_addr(line_base, issue_cnt);
    end
    if (returning) begin
      fill_addr    = word_addr(line_base, recv_cnt);
      fill_data    = mem_rdata;
      ic_fill_we   = (state == IFILL);
      dc_fill_we   = (state == DFILL);
      ic_fill_done = last_return && (state == IFILL);
      dc_fill_done = last_return && (state == DFILL);
    end
    if (state == WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = dc_wr_addr;
      mem_wdata = dc_wr_data;
      wr_ack    = 1'b1;
    end
  end

endmodule

// File: tb/tb_miss_arbiter.sv
// Bench for miss_arbiter: arbitration table, directed fill/store sequences and a random
// run checked cycle by cycle against a queue-based model of the line transfers.
module tb_miss_arbiter;

  localparam int MEM_LAT = 4;
  localparam int WORDS   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_miss, dc_miss, dc_wr_req;
  logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_data_valid;
  logic [15:0] fill_addr, fill_data;
  logic        ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, wr_ack, busy;

  always #5 clk = ~clk;

  miss_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
    .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .ic_fill_we(ic_fill_we), .dc_fill_we(dc_fill_we),
    .ic_fill_done(ic_fill_done), .dc_fill_done(dc_fill_done),
    .wr_ack(wr_ack), .busy(busy)
  );

  typedef struct packed {
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        ic_we;
    logic        dc_we;
    logic        ic_done;
    logic        dc_done;
    logic        wr_ack;
    logic        busy;
  } outv_t;

  typedef struct { int c; logic [15:0] v; logic [15:0] w; } ev_t;
  typedef struct { int ready; logic [15:0] data; } rd_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  outv_t last_out;

  // Reference model: an operation is a pair of address queues built at grant time.
  int          m_op;        // 0 idle, 1 I fill, 2 D fill, 3 store
  bit          m_last_data;
  logic [15:0] q_issue[$];
  logic [15:0] q_fill[$];

  rd_t mq[$];
  int  gap_pct = 0;
  int  stray_cnt = 0;
  bit  rand_on = 1'b0;
  bit  drop_ic, drop_dc, drop_wr;
  int  ic_data_ops = 0;

  ev_t reads[$], ifills[$], dfills[$], acks[$];
  int  idone[$], ddone[$];

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic outv_t sample();
    outv_t s;
    s.mem_en = mem_en; s.mem_wr = mem_wr; s.mem_addr = mem_addr; s.mem_wdata = mem_wdata;
    s.fill_addr = fill_addr; s.fill_data = fill_data;
    s.ic_we = ic_fill_we; s.dc_we = dc_fill_we;
    s.ic_done = ic_fill_done; s.dc_done = dc_fill_done;
    s.wr_ack = wr_ack; s.busy = busy;
    return s;
  endfunction

  function automatic outv_t mask(input outv_t v, input outv_t r);
    outv_t m = v;
    if (!r.mem_en) m.mem_addr = '0;
    if (!(r.mem_en && r.mem_wr)) m.mem_wdata = '0;
    if (!(r.ic_we || r.dc_we)) begin
      m.fill_addr = '0;
      m.fill_data = '0;
    end
    return m;
  endfunction

  function automatic outv_t model_expect();
    outv_t e = '0;
    if (m_op == 1 || m_op == 2) begin
      e.busy = 1'b1;
      if (q_issue.size() > 0) begin
        e.mem_en   = 1'b1;
        e.mem_addr = q_issue[0];
      end
      if (mem_data_valid && q_fill.size() > 0) begin
        e.ic_we     = (m_op == 1);
        e.dc_we     = (m_op == 2);
        e.fill_addr = q_fill[0];
        e.fill_data = mem_rdata;
        e.ic_done   = (m_op == 1) && (q_fill.size() == 1);
        e.dc_done   = (m_op == 2) && (q_fill.size() == 1);
      end
    end else if (m_op == 3) begin
      e.busy = 1'b1; e.mem_en = 1'b1; e.mem_wr = 1'b1;
      e.mem_addr = dc_wr_addr; e.mem_wdata = dc_wr_data; e.wr_ack = 1'b1;
    end
    return e;
  endfunction

  function automatic void model_advance();
    int pick;
    int base;
    if (rst) begin
      m_op = 0; m_last_data = 1'b0;
      q_issue.delete(); q_fill.delete();
      return;
    end
    if (m_op == 1 || m_op == 2) begin
      if (q_issue.size() > 0) void'(q_issue.pop_front());
      if (mem_data_valid && q_fill.size() > 0) begin
        void'(q_fill.pop_front());
        if (q_fill.size() == 0) begin
          m_last_data = (m_op == 2);
          m_op = 0;
        end
      end
    end else if (m_op == 3) begin
      m_last_data = 1'b1;
      m_op = 0;
    end else begin
      pick = 0;
      if (ic_miss && m_last_data) pick = 1;
      else if (dc_miss)           pick = 2;
      else if (dc_wr_req)         pick = 3;
      else if (ic_miss)           pick = 1;
      if (pick == 1 || pick == 2) begin
        base = int'((pick == 1) ? ic_miss_addr : dc_miss_addr);
        base = (base / (2 * WORDS)) * (2 * WORDS);
        for (int k = 0; k < WORDS; k++) begin
          q_issue.push_back(16'(base + 2 * k));
          q_fill.push_back(16'(base + 2 * k));
        end
      end
      m_op = pick;
    end
  endfunction

  task automatic raise_ic(input logic [15:0] a);
    ic_miss = 1'b1; ic_miss_addr = a; ic_data_ops = 0;
  endtask

  // One clock cycle: compare at the falling edge, then move inputs just after the rising edge.
  task automatic step();
    outv_t a, e;
    bit dropped_ic, dropped_dc, dropped_wr;
    @(negedge clk);
    a = sample();
    last_out = a;
    e = model_expect();
    checks++;
    if (mask(a, e) !== mask(e, e)) begin
      errors++;
      $display("FAIL cycle_outputs: got %h expected %h (cycle %0d)", mask(a, e), mask(e, e), cyc);
    end
    model_advance();
    if (a.mem_en && !a.mem_wr) reads.push_back('{cyc, a.mem_addr, 16'h0});
    if (a.ic_we) ifills.push_back('{cyc, a.fill_addr, a.fill_data});
    if (a.dc_we) dfills.push_back('{cyc, a.fill_addr, a.fill_data});
    if (a.wr_ack) acks.push_back('{cyc, a.mem_addr, a.mem_wdata});
    if (a.ic_done) idone.push_back(cyc);
    if (a.dc_done) ddone.push_back(cyc);
    if (ic_miss && (a.dc_done || a.wr_ack)) ic_data_ops++;
    if (a.ic_done) check_val("ic_wait_bound", int'(ic_data_ops <= 1), 1);
    if (a.ic_done) drop_ic = 1'b1;
    if (a.dc_done) drop_dc = 1'b1;
    if (a.wr_ack)  drop_wr = 1'b1;
    if (a.mem_en && !a.mem_wr) mq.push_back('{cyc + MEM_LAT, 16'($urandom)});
    @(posedge clk);
    #1;
    cyc++;
    dropped_ic = drop_ic; dropped_dc = drop_dc; dropped_wr = drop_wr;
    if (drop_ic) begin ic_miss = 1'b0; drop_ic = 1'b0; end
    if (drop_dc) begin dc_miss = 1'b0; drop_dc = 1'b0; end
    if (drop_wr) begin dc_wr_req = 1'b0; drop_wr = 1'b0; end
    mem_data_valid = 1'b0;
    mem_rdata = '0;
    if (stray_cnt > 0) begin
      mem_data_valid = 1'b1;
      mem_rdata = 16'($urandom);
      stray_cnt--;
    end else if (mq.size() > 0 && mq[0].ready <= cyc && $urandom_range(99) >= gap_pct) begin
      mem_data_valid = 1'b1;
      mem_rdata = mq.pop_front().data;
    end
    if (rand_on) begin
      if (!ic_miss && !dropped_ic && $urandom_range(7) == 0) raise_ic(16'($urandom));
      if (!dc_miss && !dropped_dc && $urandom_range(9) == 0) begin
        dc_miss = 1'b1; dc_miss_addr = 16'($urandom);
      end
      if (!dc_wr_req && !dropped_wr && $urandom_range(11) == 0) begin
        dc_wr_req = 1'b1; dc_wr_addr = 16'($urandom); dc_wr_data = 16'($urandom);
      end
    end
  endtask

  task automatic clear_logs();
    reads.delete(); ifills.delete(); dfills.delete(); acks.delete();
    idone.delete(); ddone.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ic_miss = 1'b0; dc_miss = 1'b0; dc_wr_req = 1'b0;
    drop_ic = 1'b0; drop_dc = 1'b0; drop_wr = 1'b0;
    stray_cnt = 0;
    step();
    mq.delete();
    step();
    rst = 1'b0;
    clear_logs();
  endtask

  typedef struct {
    bit ic; bit dc; bit wr;
    logic [15:0] ic_a; logic [15:0] dc_a; logic [15:0] wr_a; logic [15:0] wr_d;
    bit e_en; bit e_wr; logic [15:0] e_addr; bit e_busy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1;
    tbl[0] = '{1, 0, 0, 16'h1236, 16'h4008, 16'h2002, 16'hBEEF, 1, 0, 16'h1230, 1};
    tbl[1] = '{0, 1, 0, 16'h1236, 16'h4008, 16'h2002, 16'hBEEF, 1, 0, 16'h4000, 1};
    tbl[2] = '{0, 0, 1, 16'h1236, 16'h4008, 16'h2002, 16'hBEEF, 1, 1, 16'h2002, 1};
    tbl[3] = '{1, 1, 0, 16'h1236, 16'h4008, 16'h2002, 16'hBEEF, 1, 0, 16'h4000, 1};
    tbl[4] = '{1, 0, 1, 16'h1236, 16'h4008, 16'h2002, 16'hBEEF, 1, 1, 16'h2002, 1};
    tbl[5] = '{0, 1, 1, 16'h1236, 16'h4008, 16'h2002, 16'hBEEF, 1, 0, 16'h4000, 1};
    tbl[6] = '{1, 1, 1, 16'h1236, 16'h4008, 16'h2002, 16'hBEEF, 1, 0, 16'h4000, 1};
    tbl[7] = '{0, 0, 0, 16'h1236, 16'h4008, 16'h2002, 16'hBEEF, 0, 0, 16'h0000, 0};
    tbl[8] = '{1, 0, 0, 16'hFFFF, 16'h4008, 16'h2002, 16'hBEEF, 1, 0, 16'hFFF0, 1};

    rst = 1'b1;
    ic_miss = 1'b0; dc_miss = 1'b0; dc_wr_req = 1'b0;
    ic_miss_addr = '0; dc_miss_addr = '0; dc_wr_addr = '0; dc_wr_data = '0;
    mem_rdata = '0; mem_data_valid = 1'b0;
    m_op = 0; m_last_data = 1'b0;
    drop_ic = 1'b0; drop_dc = 1'b0; drop_wr = 1'b0;

    do_reset();
    step();
    checks++;
    if (last_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", last_out);
    end

    // Arbitration table: the access issued in the cycle after the request is seen.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      ic_miss = tbl[i].ic; ic_miss_addr = tbl[i].ic_a;
      dc_miss = tbl[i].dc; dc_miss_addr = tbl[i].dc_a;
      dc_wr_req = tbl[i].wr; dc_wr_addr = tbl[i].wr_a; dc_wr_data = tbl[i].wr_d;
      step();
      step();
      check_val($sformatf("tbl%0d_access", i),
                int'({last_out.mem_en, last_out.mem_wr, last_out.mem_addr, last_out.busy}),
                int'({tbl[i].e_en, tbl[i].e_wr, tbl[i].e_addr, tbl[i].e_busy}));
      if (tbl[i].e_wr)
        check_val($sformatf("tbl%0d_wdata", i), int'(last_out.mem_wdata), int'(tbl[i].wr_d));
    end

    // Single I miss at 0x1236.
    do_reset();
    raise_ic(16'h1236);
    t0 = cyc;
    repeat (20) step();
    check_val("t1_read_count", reads.size(), 8);
    for (int i = 0; i < reads.size() && i < 8; i++) begin
      check_val("t1_read_cycle", reads[i].c, t0 + 1 + i);
      check_val("t1_read_addr", int'(reads[i].v), 'h1230 + 2 * i);
    end
    check_val("t1_ifill_count", ifills.size(), 8);
    for (int i = 0; i < ifills.size() && i < 8; i++) begin
      check_val("t1_ifill_cycle", ifills[i].c, t0 + 5 + i);
      check_val("t1_ifill_addr", int'(ifills[i].v), 'h1230 + 2 * i);
    end
    check_val("t1_idone_count", idone.size(), 1);
    if (idone.size() > 0) check_val("t1_idone_cycle", idone[0], t0 + 12);
    check_val("t1_dfill_count", dfills.size(), 0);

    // Simultaneous I and D miss after reset: D line first.
    do_reset();
    raise_ic(16'h1236);
    dc_miss = 1'b1; dc_miss_addr = 16'h4008;
    t0 = cyc;
    repeat (32) step();
    check_val("t2_read_count", reads.size(), 16);
    if (reads.size() >= 9) begin
      check_val("t2_first_read", int'(reads[0].v), 'h4000);
      check_val("t2_ifill_first_cycle", reads[8].c, t0 + 14);
      check_val("t2_ifill_first_addr", int'(reads[8].v), 'h1230);
    end
    if (ddone.size() > 0) check_val("t2_ddone_cycle", ddone[0], t0 + 12);
    else check_val("t2_ddone_count", ddone.size(), 1);
    if (idone.size() > 0) check_val("t2_idone_cycle", idone[0], t0 + 25);
    else check_val("t2_idone_count", idone.size(), 1);

    // Fairness: store, then the held I miss, then a D miss raised during the I fill.
    do_reset();
    raise_ic(16'h5550);
    dc_wr_req = 1'b1; dc_wr_addr = 16'h2002; dc_wr_data = 16'hBEEF;
    t0 = cyc;
    repeat (5) step();
    dc_miss = 1'b1; dc_miss_addr = 16'h6004;
    repeat (30) step();
    check_val("t3_ack_count", acks.size(), 1);
    if (acks.size() > 0) begin
      check_val("t3_ack_cycle", acks[0].c, t0 + 1);
      check_val("t3_wr_addr", int'(acks[0].v), 'h2002);
      check_val("t3_wr_data", int'(acks[0].w), 'hBEEF);
    end
    check_val("t3_read_count", reads.size(), 16);
    if (reads.size() >= 9) begin
      check_val("t3_ifill_start", reads[0].c, t0 + 3);
      check_val("t3_ifill_addr", int'(reads[0].v), 'h5550);
      check_val("t3_dfill_start", reads[8].c, t0 + 16);
      check_val("t3_dfill_addr", int'(reads[8].v), 'h6000);
    end
    if (idone.size() > 0) check_val("t3_idone_cycle", idone[0], t0 + 14);
    else check_val("t3_idone_count", idone.size(), 1);

    // Returns with random gaps.
    do_reset();
    gap_pct = 50;
    dc_miss = 1'b1; dc_miss_addr = 16'h7A1E;
    for (int k = 0; k < 300 && ddone.size() == 0; k++) step();
    repeat (4) step();
    gap_pct = 0;
    check_val("t4_ddone_count", ddone.size(), 1);
    check_val("t4_read_count", reads.size(), 8);
    check_val("t4_dfill_count", dfills.size(), 8);
    for (int i = 0; i < dfills.size() && i < 8; i++)
      check_val("t4_dfill_addr", int'(dfills[i].v), 'h7A10 + 2 * i);
    if (dfills.size() == 8 && ddone.size() > 0)
      check_val("t4_done_on_last", ddone[0], dfills[7].c);

    // Reset during the third return of a D fill, then stray returns, then a reissue.
    do_reset();
    dc_miss = 1'b1; dc_miss_addr = 16'h4008;
    t0 = cyc;
    repeat (7) step();
    rst = 1'b1;
    dc_miss = 1'b0;
    mq.delete();
    stray_cnt = 5;
    step();
    rst = 1'b0;
    clear_logs();
    step();
    checks++;
    if (last_out !== '0) begin
      errors++;
      $display("FAIL t5_idle_after_reset: got %h expected 0", last_out);
    end
    repeat (6) step();
    mq.delete();
    check_val("t5_stray_fills", ifills.size() + dfills.size(), 0);
    check_val("t5_stray_done", idone.size() + ddone.size(), 0);
    dc_miss = 1'b1; dc_miss_addr = 16'h4008;
    t1 = cyc;
    repeat (16) step();
    check_val("t5_reissue_fills", dfills.size(), 8);
    for (int i = 0; i < dfills.size() && i < 8; i++)
      check_val("t5_reissue_addr", int'(dfills[i].v), 'h4000 + 2 * i);
    if (ddone.size() > 0) check_val("t5_reissue_done", ddone[0], t1 + 12);
    else check_val("t5_reissue_done_count", ddone.size(), 1);

    // Store raised during an I fill waits for the line to complete.
    do_reset();
    raise_ic(16'h0100);
    t0 = cyc;
    repeat (3) step();
    dc_wr_req = 1'b1; dc_wr_addr = 16'h0A0A; dc_wr_data = 16'h1234;
    repeat (20) step();
    check_val("t6_ack_count", acks.size(), 1);
    if (acks.size() > 0 && idone.size() > 0) begin
      check_val("t6_idone_cycle", idone[0], t0 + 12);
      check_val("t6_ack_after_done", acks[0].c, idone[0] + 2);
    end

    // Random traffic against the model.
    do_reset();
    gap_pct = 25;
    rand_on = 1'b1;
    repeat (2500) step();
    rand_on = 1'b0;
    ic_miss = 1'b0; dc_miss = 1'b0; dc_wr_req = 1'b0;
    for (int k = 0; k < 200 && (busy || mq.size() > 0); k++) step();
    check_val("rand_progress", int'(idone.size() > 10 && ddone.size() > 10 && acks.size() > 10), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/miss_arbiter.md
# miss_arbiter

Sequences the single-ported, multi-cycle main memory among three requesters: I-cache line fills, D-cache line fills and D-cache write-through stores. It sits between the two cache controllers and the memory model. It issues the eight pipelined word reads of a line fill and steers the returned words into the correct cache. The cache controllers hold their miss lines, and therefore the pipeline stalls, until this block signals completion.

## Interface
Parameters:
- MEM_LAT, 4: cycles from a read issue (mem_en=1, mem_wr=0) to its mem_data_valid.
- WORDS, 8: 16-bit words per cache line. Must be a power of 2. Line = 2*WORDS bytes.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ic_miss  in  1  I-cache miss pending. Level, held until ic_fill_done.
- ic_miss_addr  in  16  I-cache miss byte address.
- dc_miss  in  1  D-cache miss pending. Level, held until dc_fill_done.
- dc_miss_addr  in  16  D-cache miss byte address.
- dc_wr_req  in  1  write-through store pending. Level, held until wr_ack.
- dc_wr_addr  in  16  store byte address.
- dc_wr_data  in  16  store data.
- mem_en  out  1  memory access strobe.
- mem_wr  out  1  1=write, 0=read. Valid only with mem_en.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_data_valid  in  1  mem_rdata valid this cycle.
- fill_addr  out  16  byte address of the returned word.
- fill_data  out  16  returned word, equal to mem_rdata.
- ic_fill_we  out  1  write fill_data into the I-cache data array.
- dc_fill_we  out  1  write fill_data into the D-cache data array.
- ic_fill_done  out  1  one-cycle pulse: I-cache line complete, write tag/valid.
- dc_fill_done  out  1  one-cycle pulse: D-cache line complete, write tag/valid.
- wr_ack  out  1  one-cycle pulse: store issued to memory.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, IFILL, DFILL, WRITE.
- IDLE arbitration, evaluated each cycle from registered requests:
  - Candidates are dc_miss, dc_wr_req and ic_miss.
  - Base priority: dc_miss > dc_wr_req > ic_miss.
  - Fairness: if the last completed operation was data-side (DFILL or WRITE) and ic_miss=1, ic_miss wins.
  - last_side resets to instruction-side.
- Grant latches the line base {addr[15:log2(2*WORDS)], 0} and clears issue_cnt and recv_cnt.
- IFILL/DFILL, issue phase: while issue_cnt < WORDS, drive mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt, then issue_cnt++. One read per cycle, no gaps.
- IFILL/DFILL, return phase: on each mem_data_valid:
  - fill_data = mem_rdata.
  - fill_addr = base + 2*recv_cnt.
  - the owning fill_we (ic_fill_we in IFILL, dc_fill_we in DFILL) = 1.
  - recv_cnt++.
  - On the return where recv_cnt = WORDS-1, the matching *_fill_done pulses in the same cycle and the next state is IDLE.
- WRITE: exactly one cycle. mem_en=1, mem_wr=1, mem_addr=dc_wr_addr, mem_wdata=dc_wr_data, wr_ack=1. Next state is IDLE.
- Requests are not preempted. A miss or store arriving mid-operation waits for IDLE.
- mem_data_valid in IDLE or WRITE (stray returns after reset) is ignored: no fill_we, no counter change.
- Word writes within a line are in ascending address order from the line base (no critical-word-first).

## Timing
- Reset values: all outputs 0. State IDLE, counters 0, last_side = instruction.
- Reset in any state returns to IDLE next cycle and aborts the fill. No done pulse is generated. Requesters reissue.
- A request seen in IDLE at cycle T:
  - For a fill, the first read issues at T+1 and the last at T+WORDS.
  - Words return at T+1+MEM_LAT through T+WORDS+MEM_LAT.
  - *_fill_done coincides with the last word (T+12 at defaults). State is IDLE at T+13.
- A store seen at T: mem write and wr_ack at T+1, IDLE at T+2.
- Back-to-back: a request still asserted in the first IDLE cycle is granted there. Controllers must drop the completed request on the edge after its done or ack pulse. The arbiter does not re-grant a request in the cycle its done or ack pulse is high, because the state is not IDLE in that cycle.
- Simultaneous ic_miss and dc_miss at T with last_side=instruction: D fill first. The I fill is granted in the IDLE cycle after dc_fill_done.
- Worst-case I-side wait: one data-side operation.
- busy is high from T+1 through the done or ack cycle inclusive.

## Test plan
- Single I miss, ic_miss_addr=0x1236 at T: reads 0x1230…0x123E at T+1..T+8. Eight ic_fill_we strobes at T+5..T+12 with matching fill_addr. ic_fill_done at T+12. dc_fill_we stays 0 throughout.
- Simultaneous ic_miss and dc_miss (dc_miss_addr=0x4008) after reset: DFILL on base 0x4000 first. IFILL issues its first read in the cycle after IDLE follows dc_fill_done.
- Fairness: dc_wr_req (0x2002, 0xBEEF) and ic_miss both held. Order must be WRITE (mem_wr=1, mem_wdata=0xBEEF, wr_ack), then IFILL, then any new dc_miss. This holds even with dc_miss asserted during IFILL.
- Memory return with variable spacing (mem_data_valid gaps injected): all 8 words are written in order, done fires only on the 8th, and no extra reads are issued.
- Reset asserted at the 3rd return of a DFILL: the next cycle is IDLE with all outputs 0. The 5 stray mem_data_valid pulses produce no fill_we or done. A reissued dc_miss completes correctly.
- Store during an active IFILL: wr_ack is withheld until after ic_fill_done, and mem_en is never driven by two operations in one cycle.
